// File: rtl/if_prefetch_queue.sv
// Instruction-fetch front end: issues sequential reads to a variable-latency
// instruction memory, buffers returned words with their PCs in a small FIFO,
// and presents them to decode through a valid/ready handshake. A redirect
// flushes the queue and squashes any in-flight word so decode never sees a
// wrong-path instruction.
module if_prefetch_queue #(
  parameter int              AW       = 16,
  parameter int              DW       = 16,
  parameter int              DEPTH    = 4,
  parameter logic [AW-1:0]   RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       mem_req,
  output logic [AW-1:0]              mem_addr,
  input  logic                       mem_ack,
  input  logic [DW-1:0]              mem_rdata,
  output logic                       id_valid,
  output logic [DW-1:0]              id_instr,
  output logic [AW-1:0]              id_pc,
  input  logic                       id_ready,
  input  logic                       redirect,
  input  logic [AW-1:0]              redirect_pc,
  input  logic                       hlt,
  output logic [AW-1:0]              fetch_pc,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // WAIT: live request outstanding; DROP: request outstanding whose word is squashed
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_DROP = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   fetch_pc_q, fetch_pc_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            req_q, req_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [DW-1:0]   data_q [DEPTH];
  logic [AW-1:0]   pc_q   [DEPTH];

  logic            pop_s;
  logic            push_s;
  logic [CW:0]     cnt_after_s;
  logic [AW-1:0]   pc_inc_s;

  // Next-state logic for the fetch FSM, request port and FIFO bookkeeping
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    addr_d      = addr_q;
    count_d     = count_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    push_s      = 1'b0;
    pop_s       = (count_q != {CW{1'b0}}) && id_ready;
    pc_inc_s    = fetch_pc_q + AW'(1);
    // occupancy if the current word is pushed; used to decide back-to-back issue
    cnt_after_s = {1'b0, count_q} + (CW+1)'(1) - (CW+1)'(pop_s);

    case (state_q)
      ST_IDLE: begin
        if (redirect) begin
          fetch_pc_d = redirect_pc;
        end else if (!hlt && (count_q < DEPTH_C)) begin
          state_d = ST_WAIT;
          addr_d  = fetch_pc_q;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (mem_ack) begin
          if (redirect) begin
            fetch_pc_d = redirect_pc;
            state_d    = ST_IDLE;
          end else begin
            push_s     = 1'b1;
            fetch_pc_d = pc_inc_s;
            if (!hlt && (cnt_after_s < {1'b0, DEPTH_C})) begin
              addr_d = pc_inc_s;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end else if (redirect) begin
          fetch_pc_d = redirect_pc;
          state_d    = ST_DROP;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DROP: begin
        if (redirect) begin
          fetch_pc_d = redirect_pc;
        end else begin
          fetch_pc_d = fetch_pc_q;
        end
        if (mem_ack) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DROP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // a redirect flushes the queue and overrides any same-cycle push or pop
    if (redirect) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      count_d = count_q + CW'(push_s) - CW'(pop_s);
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
    end

    req_d = (state_d == ST_WAIT) || (state_d == ST_DROP);
  end

  // State, PC, request and FIFO pointer registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      req_q      <= 1'b0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // FIFO storage; contents are only observable through a valid head entry
  always_ff @(posedge clk) begin
    if (push_s && !redirect) begin
      data_q[wr_ptr_q] <= mem_rdata;
      pc_q[wr_ptr_q]   <= fetch_pc_q;
    end else begin
      data_q[wr_ptr_q] <= data_q[wr_ptr_q];
      pc_q[wr_ptr_q]   <= pc_q[wr_ptr_q];
    end
  end

  assign mem_req  = req_q;
  assign mem_addr = addr_q;
  assign fetch_pc = fetch_pc_q;
  assign count    = count_q;
  assign id_valid = (count_q != {CW{1'b0}});
  assign id_instr = id_valid ? data_q[rd_ptr_q] : '0;
  assign id_pc    = id_valid ? pc_q[rd_ptr_q]   : '0;

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Self-checking bench for if_prefetch_queue: a queue-based reference model is
// stepped every cycle and compared against all DUT outputs, and directed
// scenarios pin the model with hand-computed literal expectations.
module tb_if_prefetch_queue;

  logic        clk;
  logic        rst;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        id_valid;
  logic [15:0] id_instr;
  logic [15:0] id_pc;
  logic        id_ready;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        hlt;
  logic [15:0] fetch_pc;
  logic [2:0]  count;

  if_prefetch_queue #(.AW(16), .DW(16), .DEPTH(4), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .id_valid(id_valid),
    .id_instr(id_instr), .id_pc(id_pc), .id_ready(id_ready),
    .redirect(redirect), .redirect_pc(redirect_pc), .hlt(hlt),
    .fetch_pc(fetch_pc), .count(count)
  );

  always #5 clk = ~clk;

  int n_err;
  int n_checks;

  // reference model: queue contents, fetch pointer, outstanding request
  logic [15:0] m_pc[$];
  logic [15:0] m_ins[$];
  logic [15:0] m_fpc;
  logic [15:0] m_addr;
  int          m_out;   // 0 none, 1 live request, 2 squashed request

  // memory responder state and logs
  int          lat;
  int          age;
  logic [15:0] req_log[$];
  logic [15:0] cons_pc[$];
  logic [15:0] cons_ins[$];

  function automatic logic [15:0] memf(input logic [15:0] a);
    return a ^ 16'hC3A0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int  sz;
    bit  pop;
    int  nsz;
    sz  = m_pc.size();
    pop = (sz > 0) && id_ready;
    if (rst) begin
      m_pc.delete(); m_ins.delete();
      m_fpc = 16'h0000; m_addr = 16'h0000; m_out = 0;
    end else begin
      if (m_out == 0) begin
        if (redirect) m_fpc = redirect_pc;
        else if (!hlt && sz < 4) begin m_out = 1; m_addr = m_fpc; end
        if (!redirect && pop) begin void'(m_pc.pop_front()); void'(m_ins.pop_front()); end
      end else if (m_out == 1) begin
        if (mem_ack && !redirect) begin
          nsz = sz + 1 - (pop ? 1 : 0);
          if (pop) begin void'(m_pc.pop_front()); void'(m_ins.pop_front()); end
          m_pc.push_back(m_fpc); m_ins.push_back(mem_rdata);
          m_fpc = m_fpc + 16'h0001;
          if (!hlt && nsz < 4) m_addr = m_fpc;
          else m_out = 0;
        end else if (redirect) begin
          m_fpc = redirect_pc;
          m_out = mem_ack ? 0 : 2;
        end else if (pop) begin
          void'(m_pc.pop_front()); void'(m_ins.pop_front());
        end
      end else begin
        if (redirect) m_fpc = redirect_pc;
        if (mem_ack) m_out = 0;
        if (!redirect && pop) begin void'(m_pc.pop_front()); void'(m_ins.pop_front()); end
      end
      if (redirect) begin m_pc.delete(); m_ins.delete(); end
    end
  endtask

  task automatic compare_all();
    bit v;
    v = (m_pc.size() != 0);
    chk("mem_req",  32'(mem_req),  32'(m_out != 0));
    chk("mem_addr", 32'(mem_addr), 32'(m_addr));
    chk("fetch_pc", 32'(fetch_pc), 32'(m_fpc));
    chk("count",    32'(count),    32'(m_pc.size()));
    chk("id_valid", 32'(id_valid), 32'(v));
    chk("id_pc",    32'(id_pc),    v ? 32'(m_pc[0])  : 32'h0);
    chk("id_instr", 32'(id_instr), v ? 32'(m_ins[0]) : 32'h0);
  endtask

  task automatic drive_mem();
    if (!mem_req) begin
      age = 0; mem_ack = 1'b0;
    end else begin
      if (age == 0 || mem_ack) begin age = 1; req_log.push_back(mem_addr); end
      else age++;
      mem_ack = (age >= lat);
    end
    mem_rdata = mem_ack ? memf(mem_addr) : 16'hDEAD;
  endtask

  task automatic tick();
    if (!rst && !redirect && id_valid && id_ready) begin
      cons_pc.push_back(id_pc); cons_ins.push_back(id_instr);
    end
    model_step();
    @(posedge clk); #1;
    compare_all();
    drive_mem();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect = 1'b0; hlt = 1'b0; id_ready = 1'b0; redirect_pc = 16'h0000;
    run(2);
    chk("rst_mem_req",  32'(mem_req),  32'h0);
    chk("rst_count",    32'(count),    32'h0);
    chk("rst_id_valid", 32'(id_valid), 32'h0);
    chk("rst_fetch_pc", 32'(fetch_pc), 32'h0000);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0000);
    rst = 1'b0;
    cons_pc.delete(); cons_ins.delete(); req_log.delete();
  endtask

  initial begin
    int k;
    int hits;
    clk = 1'b0; n_err = 0; n_checks = 0; age = 0; lat = 1;
    mem_ack = 1'b0; mem_rdata = 16'hDEAD;
    m_fpc = 16'h0; m_addr = 16'h0; m_out = 0;

    // 1: single-cycle memory, decode always ready
    lat = 1; do_reset(); id_ready = 1'b1;
    run(10);
    chk("t1_ncons", 32'(cons_pc.size() >= 4), 32'h1);
    if (cons_pc.size() >= 4) begin
      chk("t1_pc0", 32'(cons_pc[0]), 32'h0000); chk("t1_ins0", 32'(cons_ins[0]), 32'hC3A0);
      chk("t1_pc1", 32'(cons_pc[1]), 32'h0001); chk("t1_ins1", 32'(cons_ins[1]), 32'hC3A1);
      chk("t1_pc2", 32'(cons_pc[2]), 32'h0002); chk("t1_ins2", 32'(cons_ins[2]), 32'hC3A2);
      chk("t1_pc3", 32'(cons_pc[3]), 32'h0003); chk("t1_ins3", 32'(cons_ins[3]), 32'hC3A3);
    end
    chk("t1_req3", 32'(req_log.size() >= 4 ? req_log[3] : 16'hFFFF), 32'h0003);

    // 2: decode stalled from reset fills the queue, then drains without loss
    lat = 1; do_reset(); id_ready = 1'b0;
    run(8);
    chk("t2_count_full", 32'(count),    32'h4);
    chk("t2_req_low",    32'(mem_req),  32'h0);
    chk("t2_fetch_pc",   32'(fetch_pc), 32'h0004);
    id_ready = 1'b1;
    run(14);
    chk("t2_ncons", 32'(cons_pc.size() >= 8), 32'h1);
    if (cons_pc.size() >= 8)
      for (int i = 0; i < 8; i++) chk("t2_seq", 32'(cons_pc[i]), 32'(i));

    // 3: redirect while waiting on a slow fetch of address 5
    lat = 3; do_reset(); id_ready = 1'b1;
    k = 0;
    while (!(mem_req && mem_addr == 16'h0005) && k < 60) begin tick(); k++; end
    chk("t3_reach_addr5", 32'(k < 60), 32'h1);
    redirect = 1'b1; redirect_pc = 16'h0040; req_log.delete();
    tick();
    redirect = 1'b0;
    chk("t3_count0",  32'(count),    32'h0);
    chk("t3_drop_req", 32'(mem_req), 32'h1);
    chk("t3_drop_addr", 32'(mem_addr), 32'h0005);
    cons_pc.delete(); cons_ins.delete();
    run(16);
    chk("t3_next_req", 32'(req_log.size() > 0 ? req_log[0] : 16'hFFFF), 32'h0040);
    chk("t3_first_pc", 32'(cons_pc.size() > 0 ? cons_pc[0] : 16'hFFFF), 32'h0040);
    hits = 0;
    foreach (cons_pc[i]) if (cons_pc[i] == 16'h0005) hits++;
    chk("t3_no_pc5", 32'(hits), 32'h0);

    // 4: redirect coinciding with ack and pop while two words are queued
    lat = 2; do_reset(); id_ready = 1'b0;
    k = 0;
    while (!(count == 3'd2 && mem_ack) && k < 40) begin tick(); k++; end
    chk("t4_reach", 32'(k < 40), 32'h1);
    redirect = 1'b1; redirect_pc = 16'h0100; id_ready = 1'b1; req_log.delete();
    tick();
    redirect = 1'b0;
    chk("t4_count0", 32'(count),    32'h0);
    chk("t4_valid0", 32'(id_valid), 32'h0);
    cons_pc.delete(); cons_ins.delete();
    run(10);
    chk("t4_next_req", 32'(req_log.size() > 0 ? req_log[0] : 16'hFFFF), 32'h0100);
    chk("t4_first_pc", 32'(cons_pc.size() > 0 ? cons_pc[0] : 16'hFFFF), 32'h0100);

    // 5: halt during an outstanding fetch, then resume
    lat = 3; do_reset(); id_ready = 1'b1;
    k = 0;
    while (!(mem_req && mem_addr == 16'h0002) && k < 40) begin tick(); k++; end
    chk("t5_reach", 32'(k < 40), 32'h1);
    hlt = 1'b1;
    run(8);
    chk("t5_req_low",  32'(mem_req),  32'h0);
    chk("t5_fetch_pc", 32'(fetch_pc), 32'h0003);
    chk("t5_last_pc",  32'(cons_pc.size() > 0 ? cons_pc[cons_pc.size()-1] : 16'hFFFF), 32'h0002);
    chk("t5_empty",    32'(count),    32'h0);
    hlt = 1'b0; req_log.delete();
    run(8);
    chk("t5_resume", 32'(req_log.size() > 0 ? req_log[0] : 16'hFFFF), 32'h0003);

    // 6: redirect near the top of the address space wraps to zero
    lat = 1; do_reset(); id_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 16'hFFFE;
    tick();
    redirect = 1'b0; cons_pc.delete(); cons_ins.delete();
    chk("t6_req_t1", 32'(mem_req), 32'h0);
    tick();
    chk("t6_req_t2",  32'(mem_req),  32'h1);
    chk("t6_addr_t2", 32'(mem_addr), 32'hFFFE);
    run(10);
    chk("t6_ncons", 32'(cons_pc.size() >= 4), 32'h1);
    if (cons_pc.size() >= 4) begin
      chk("t6_pc0", 32'(cons_pc[0]), 32'hFFFE); chk("t6_ins0", 32'(cons_ins[0]), 32'h3C5E);
      chk("t6_pc1", 32'(cons_pc[1]), 32'hFFFF); chk("t6_ins1", 32'(cons_ins[1]), 32'h3C5F);
      chk("t6_pc2", 32'(cons_pc[2]), 32'h0000); chk("t6_ins2", 32'(cons_ins[2]), 32'hC3A0);
      chk("t6_pc3", 32'(cons_pc[3]), 32'h0001); chk("t6_ins3", 32'(cons_ins[3]), 32'hC3A1);
    end

    // reset in the middle of an outstanding request abandons it
    lat = 4; id_ready = 1'b0;
    run(3);
    do_reset();
    run(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
